ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: loader wait cycles before the CPU is forcibly stalled.
REQ-002 sysclk  in  1  system clock; all state updates on its rising edge.
REQ-003 clear  in  1  reset, synchronous, active-high.
REQ-004 clken  in  1  CPU clock-enable from the clock generator.
REQ-005 clken_cpu  out  1  gated enable to controlunit: clken AND NOT cpu_stall.
REQ-006 cpu_halt  in  1  CPU halted (controlunit halt).
REQ-007 cpu_mem_en  in  1  CPU drives RAM onto the bus this cycle (MEM_EN bit).
REQ-008 cpu_addr  in  4  MAR contents.
REQ-009 cpu_rdata  out  8  RAM read data to the bus, equal to ram_rdata.
REQ-010 ld_req  in  1  loader write request, level; ld_addr/ld_wdata stable while high.
REQ-011 ld_addr  in  4; ld_wdata  in  8  loader address and data.
REQ-012 ld_gnt  out  1  high in the cycle the loader write is issued.
REQ-013 ld_done  out  1  one-cycle pulse when a loader transaction completes.
REQ-014 ld_err  out  1  sticky readback-mismatch flag; present only with the macro of REQ-032.
REQ-015 ram_addr  out  4; ram_we  out  1; ram_wdata  out  8; ram_rdata  in  8  16x8 RAM port, asynchronous read, write at sysclk edge when ram_we is high.

Function
REQ-016 Moore FSM states: IDLE, LD_WRITE, LD_VERIFY (macro only), LD_DONE; all outputs decode from registered state.
REQ-017 IDLE: ram_addr=cpu_addr, ram_we=0, cpu_stall=0, ld_gnt=0.
REQ-018 IDLE -> LD_WRITE when ld_req AND (cpu_halt OR NOT cpu_mem_en OR starve_cnt==STARVE_LIMIT).
REQ-019 LD_WRITE: ram_addr=ld_addr, ram_wdata=ld_wdata, ram_we=1, ld_gnt=1, cpu_stall=1; lasts exactly one cycle.
REQ-020 LD_WRITE -> LD_VERIFY with the macro; otherwise -> LD_DONE.
REQ-021 LD_VERIFY: ram_addr=ld_addr, ram_we=0, cpu_stall=1; ld_err sets if ram_rdata != ld_wdata; -> LD_DONE.
REQ-022 LD_DONE: ld_done=1, cpu_stall=0, ram_addr=cpu_addr; -> IDLE unconditionally, so back-to-back requests are separated by at least one IDLE cycle.
REQ-023 Latency from the edge leaving IDLE to the ld_done pulse: 1 cycle without the macro, 2 cycles with it.
REQ-024 starve_cnt (0..STARVE_LIMIT):
- increments in IDLE while ld_req=1 and no grant is issued;
- saturates at STARVE_LIMIT;
- clears on entry to LD_WRITE or when ld_req=0.
REQ-025 A forced grant (starve_cnt==STARVE_LIMIT with cpu_mem_en=1) stalls the CPU; its T-state does not advance, so the deferred MEM_EN cycle repeats after LD_DONE.
REQ-026 cpu_halt=1: the loader is granted on the first IDLE cycle with ld_req=1, regardless of cpu_mem_en.
REQ-027 ld_req dropped during LD_WRITE/LD_VERIFY: the transaction still completes and ld_done still pulses.

Reset
REQ-028 clear at an edge: state=IDLE, starve_cnt=0, ld_err=0; clear has priority over all transitions.
REQ-029 Outputs while clear is held: ram_we=0, ld_gnt=0, ld_done=0, clken_cpu=clken.
REQ-030 clear during LD_WRITE: the write at that edge still commits, and no ld_done pulse is produced.
REQ-031 ld_err also clears on entry to LD_WRITE.

Configuration
REQ-032 Macro RAM_ARB_VERIFY_EN:
- defined: LD_VERIFY state exists and ld_err is live;
- undefined: LD_VERIFY is absent and ld_err is tied 0.

Structure
REQ-033 Shared package sap_pkg holds the FSM state typedef, ADDR_W=4, DATA_W=8 and the STARVE_LIMIT default.
REQ-034 One sub-module, starve_ctr, implements the saturating counter of REQ-024.

Verification
REQ-035 cpu_halt=1, ld_req, addr 0x3, data 0x5A -> ld_gnt and ram_we for 1 cycle; ld_done one cycle later (two with the macro); RAM[3]=0x5A.
REQ-036 cpu_mem_en held 1, cpu_halt=0, ld_req held -> no grant for 8 cycles; forced grant on cycle 9; clken_cpu=0 while stalled.
REQ-037 RAM_ARB_VERIFY_EN defined, RAM model corrupts bit 0 of the write -> ld_err=1 after ld_done; the next accepted ld_req clears it.
REQ-038 clear asserted in LD_WRITE -> write commits, state IDLE next cycle, no ld_done pulse, starve_cnt=0.
REQ-039 Two back-to-back ld_req to 0xE and 0xF with the CPU idle -> two grants separated by at least one IDLE cycle; both bytes written.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared sizes and FSM state type for the SAP RAM arbiter.
// RAM_ARB_VERIFY_EN adds the LD_VERIFY readback state.
package sap_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef enum logic [1:0] {
        IDLE,
        LD_WRITE,
`ifdef RAM_ARB_VERIFY_EN
        LD_VERIFY,
`endif
        LD_DONE
    } arb_state_e;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, loader and RAM-port signals around the RAM arbiter.
interface ram_arbiter_if;
    import sap_pkg::*;
    logic              clken, clken_cpu, cpu_halt, cpu_mem_en;
    logic [ADDR_W-1:0] cpu_addr, ld_addr, ram_addr;
    logic [DATA_W-1:0] cpu_rdata, ld_wdata, ram_wdata, ram_rdata;
    logic              ld_req, ld_gnt, ld_done, ld_err, ram_we;
    modport slave (
        input  clken, cpu_halt, cpu_mem_en, cpu_addr, ld_req, ld_addr, ld_wdata, ram_rdata,
        output clken_cpu, cpu_rdata, ld_gnt, ld_done, ld_err, ram_addr, ram_we, ram_wdata
    );
    modport master (
        output clken, cpu_halt, cpu_mem_en, cpu_addr, ld_req, ld_addr, ld_wdata, ram_rdata,
        input  clken_cpu, cpu_rdata, ld_gnt, ld_done, ld_err, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/starve_ctr.sv
// starve_ctr: counts loader wait cycles, saturating at LIMIT; clr_i wins over inc_i.
module starve_ctr #(
    parameter int LIMIT = 8,
    parameter int W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
    assign sat_o = cnt_q == W'(LIMIT);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the SAP 16x8 RAM between the CPU and a byte loader.
// RAM_ARB_VERIFY_EN adds a readback cycle and the sticky ld_err flag.
module ram_arbiter
    import sap_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic          sysclk,
    input logic          clear,
    ram_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    logic       idle, grant, sat, busy;
    assign idle  = state_q == IDLE;
    assign grant = idle && bus.ld_req && (bus.cpu_halt || !bus.cpu_mem_en || sat);
    starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk  (sysclk),
        .rst  (clear),
        .clr_i(grant || !bus.ld_req),
        .inc_i(idle && bus.ld_req && !grant),
        .sat_o(sat)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = grant ? LD_WRITE : IDLE;
`ifdef RAM_ARB_VERIFY_EN
            LD_WRITE:  state_d = LD_VERIFY;
            LD_VERIFY: state_d = LD_DONE;
`else
            LD_WRITE:  state_d = LD_DONE;
`endif
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge sysclk) begin
        state_q <= clear ? IDLE : state_d;
    end
`ifdef RAM_ARB_VERIFY_EN
    logic err_q, err_d;
    always_comb begin
        err_d = grant ? 1'b0 : (state_q == LD_VERIFY && bus.ram_rdata != bus.ld_wdata) ? 1'b1 : err_q;
    end
    always_ff @(posedge sysclk) begin
        err_q <= clear ? 1'b0 : err_d;
    end
    assign busy       = state_q == LD_WRITE || state_q == LD_VERIFY;
    assign bus.ld_err = err_q;
`else
    assign busy       = state_q == LD_WRITE;
    assign bus.ld_err = 1'b0;
`endif
    // A stalled CPU holds its T-state, so a deferred MEM_EN cycle simply repeats.
    assign bus.clken_cpu = bus.clken && !busy;
    assign bus.ram_addr  = busy ? bus.ld_addr : bus.cpu_addr;
    assign bus.ram_wdata = bus.ld_wdata;
    assign bus.ram_we    = state_q == LD_WRITE;
    assign bus.ld_gnt    = state_q == LD_WRITE;
    assign bus.ld_done   = state_q == LD_DONE;
    assign bus.cpu_rdata = bus.ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors and corner-case sequences for ram_arbiter.
module tb_ram_arbiter;
`ifdef RAM_ARB_VERIFY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic sysclk = 1'b0, clear, init, corrupt;
    logic [7:0] mem [16];
    int n_chk = 0, n_fail = 0;
    ram_arbiter_if bus();
    ram_arbiter dut (.sysclk(sysclk), .clear(clear), .bus(bus));
    always #5 sysclk = ~sysclk;
    // RAM with asynchronous read; corrupt flips bit 0 of every write.
    always @(posedge sysclk) begin
        if (init) for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata ^ {7'd0, corrupt};
    end
    assign bus.ram_rdata = mem[bus.ram_addr];
    typedef struct {
        logic       clken, halt, mem_en;
        logic [3:0] addr, e_addr;
        logic       e_clken_cpu;
        logic [7:0] e_rdata;
    } vec_t;
    vec_t tv [5];
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic run_to_done(input string nm);
        int n = 0;
        while (!bus.ld_done && n < 6) begin
            tick();
            n++;
        end
        chk(nm, n, LAT);
    endtask
    initial begin
        tv[0] = '{1'b1, 1'b0, 1'b1, 4'h3, 4'h3, 1'b1, 8'h33};
        tv[1] = '{1'b0, 1'b0, 1'b0, 4'h7, 4'h7, 1'b0, 8'h77};
        tv[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 8'hFF};
        tv[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h00};
        tv[4] = '{1'b0, 1'b1, 1'b1, 4'hA, 4'hA, 1'b0, 8'hAA};
        clear = 1; init = 1; corrupt = 0;
        bus.clken = 1; bus.cpu_halt = 0; bus.cpu_mem_en = 0; bus.cpu_addr = 0;
        bus.ld_req = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
        repeat (2) tick();
        init = 0;
        chk("rst_gnt", bus.ld_gnt, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_done", bus.ld_done, 0);
        chk("rst_err", bus.ld_err, 0);
        chk("rst_clken_cpu", bus.clken_cpu, 1);
        clear = 0;
        for (int i = 0; i < 5; i++) begin
            bus.clken = tv[i].clken; bus.cpu_halt = tv[i].halt;
            bus.cpu_mem_en = tv[i].mem_en; bus.cpu_addr = tv[i].addr;
            tick();
            chk($sformatf("idle%0d_addr", i), bus.ram_addr, tv[i].e_addr);
            chk($sformatf("idle%0d_clken", i), bus.clken_cpu, tv[i].e_clken_cpu);
            chk($sformatf("idle%0d_rdata", i), bus.cpu_rdata, tv[i].e_rdata);
            chk($sformatf("idle%0d_we", i), bus.ram_we, 0);
            chk($sformatf("idle%0d_gnt", i), bus.ld_gnt, 0);
        end
        // halted CPU: immediate grant even with MEM_EN set; ld_req dropped mid-transaction
        bus.clken = 1; bus.cpu_halt = 1; bus.cpu_mem_en = 1; bus.cpu_addr = 4'h0;
        bus.ld_req = 1; bus.ld_addr = 4'h3; bus.ld_wdata = 8'h5A;
        tick();
        chk("h_gnt", bus.ld_gnt, 1);
        chk("h_we", bus.ram_we, 1);
        chk("h_addr", bus.ram_addr, 4'h3);
        chk("h_wdata", bus.ram_wdata, 8'h5A);
        chk("h_clken_cpu", bus.clken_cpu, 0);
        bus.ld_req = 0;
        run_to_done("h_latency");
        chk("h_done_gnt", bus.ld_gnt, 0);
        chk("h_done_clken", bus.clken_cpu, 1);
        chk("h_mem3", mem[3], 8'h5A);
        chk("h_err", bus.ld_err, 0);
        tick();
        chk("h_done_pulse", bus.ld_done, 0);
        // starvation: dropping ld_req resets the wait count
        bus.cpu_halt = 0; bus.cpu_mem_en = 1; bus.cpu_addr = 4'hB;
        bus.ld_req = 1; bus.ld_addr = 4'h5; bus.ld_wdata = 8'hC3;
        repeat (5) tick();
        chk("s_pre_gnt", bus.ld_gnt, 0);
        bus.ld_req = 0;
        tick();
        bus.ld_req = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("s_wait%0d", i), bus.ld_gnt, 0);
        end
        tick();
        chk("s_forced_gnt", bus.ld_gnt, 1);
        chk("s_stall", bus.clken_cpu, 0);
        chk("s_addr", bus.ram_addr, 4'h5);
        run_to_done("s_latency");
        chk("s_done_clken", bus.clken_cpu, 1);
        chk("s_done_addr", bus.ram_addr, 4'hB);
        chk("s_mem5", mem[5], 8'hC3);
        bus.ld_req = 0;
        tick();
        // clear zeroes a partly counted wait
        bus.ld_req = 1;
        repeat (3) tick();
        chk("c_cnt3", 32'(dut.u_starve.cnt_q), 3);
        clear = 1;
        tick();
        chk("c_cnt0", 32'(dut.u_starve.cnt_q), 0);
        chk("c_gnt", bus.ld_gnt, 0);
        clear = 0; bus.ld_req = 0;
        tick();
        // clear during LD_WRITE: write lands, no done pulse
        bus.cpu_halt = 1; bus.ld_req = 1; bus.ld_addr = 4'h9; bus.ld_wdata = 8'h3C;
        tick();
        chk("cw_gnt", bus.ld_gnt, 1);
        clear = 1;
        tick();
        chk("cw_mem9", mem[9], 8'h3C);
        chk("cw_done", bus.ld_done, 0);
        chk("cw_gnt_off", bus.ld_gnt, 0);
        chk("cw_we_off", bus.ram_we, 0);
        clear = 0; bus.ld_req = 0;
        tick();
        chk("cw_done2", bus.ld_done, 0);
        // back-to-back requests with the CPU idle
        bus.cpu_halt = 0; bus.cpu_mem_en = 0;
        bus.ld_req = 1; bus.ld_addr = 4'hE; bus.ld_wdata = 8'hE1;
        tick();
        chk("b_gnt1", bus.ld_gnt, 1);
        run_to_done("b_latency1");
        bus.ld_addr = 4'hF; bus.ld_wdata = 8'hF2;
        tick();
        chk("b_gap_gnt", bus.ld_gnt, 0);
        chk("b_gap_done", bus.ld_done, 0);
        tick();
        chk("b_gnt2", bus.ld_gnt, 1);
        chk("b_addr2", bus.ram_addr, 4'hF);
        bus.ld_req = 0;
        run_to_done("b_latency2");
        chk("b_memE", mem[14], 8'hE1);
        chk("b_memF", mem[15], 8'hF2);
        tick();
`ifdef RAM_ARB_VERIFY_EN
        corrupt = 1; bus.cpu_halt = 1;
        bus.ld_req = 1; bus.ld_addr = 4'h2; bus.ld_wdata = 8'h80;
        tick();
        bus.ld_req = 0;
        run_to_done("v_latency");
        chk("v_err_set", bus.ld_err, 1);
        tick();
        chk("v_err_sticky", bus.ld_err, 1);
        corrupt = 0; bus.ld_req = 1; bus.ld_wdata = 8'h81;
        tick();
        chk("v_err_clr", bus.ld_err, 0);
        bus.ld_req = 0;
        run_to_done("v_latency2");
        chk("v_err_ok", bus.ld_err, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
